fetch_sequencer: RTL and testbench

Instruction-fetch controller that sequences the instruction ROM. It owns the program counter and drives the ROM address, then registers the returned word into an instruction register for the decode stage. It applies absolute and PC-relative redirects, stalls, and halt, and reports run status and a cycle count to the testbench/top level. It sits between the top-level Start/Done handshake, the instruction ROM (combinational read, address in, word out) and the decode/execute logic.

---
 rtl/fetch_sequencer_if.sv | 55 +++++
 rtl/fetch_sequencer.sv | 114 +++++++++++
 tb/tb_fetch_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: start/status, instruction ROM port and decode-side
// redirect/stall/halt controls grouped into one interface.
interface fetch_sequencer_if #(
  parameter int A = 16,
  parameter int W = 9
);
  logic         Start;
  logic [A-1:0] InstAddress;
  logic [W-1:0] InstIn;
  logic [W-1:0] InstOut;
  logic [A-1:0] InstPC;
  logic         InstValid;
  logic         Stall;
  logic         BranchAbs;
  logic         BranchRel;
  logic [A-1:0] Target;
  logic         HaltReq;
  logic         Busy;
  logic         Done;
  logic [15:0]  CycleCount;

  modport master (
    input  Start,
    input  InstIn,
    input  Stall,
    input  BranchAbs,
    input  BranchRel,
    input  Target,
    input  HaltReq,
    output InstAddress,
    output InstOut,
    output InstPC,
    output InstValid,
    output Busy,
    output Done,
    output CycleCount
  );

  modport slave (
    output Start,
    output InstIn,
    output Stall,
    output BranchAbs,
    output BranchRel,
    output Target,
    output HaltReq,
    input  InstAddress,
    input  InstOut,
    input  InstPC,
    input  InstValid,
    input  Busy,
    input  Done,
    input  CycleCount
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, registers ROM words for decode,
// applies redirects, stalls and halt, and counts cycles spent running.
module fetch_sequencer #(
  parameter int           A          = 16,
  parameter int           W          = 9,
  parameter logic [A-1:0] START_ADDR = '0
) (
  input logic                  Clk,
  input logic                  Reset_n,
  fetch_sequencer_if.master    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state, state_nx;
  logic [A-1:0] pc, pc_nx;
  logic [A-1:0] inst_pc, inst_pc_nx;
  logic [W-1:0] inst, inst_nx;
  logic         valid, valid_nx;
  logic [15:0]  cycles, cycles_nx;

  logic         halt_go;
  logic         abs_go;
  logic         rel_go;
  logic [15:0]  cycles_inc;

  // Mutually exclusive so the RUN decoder can be a unique case
  assign halt_go = bus.HaltReq && valid;
  assign abs_go  = bus.BranchAbs && valid && !bus.HaltReq;
  assign rel_go  = bus.BranchRel && valid && !bus.HaltReq
                   && !bus.BranchAbs;

  assign cycles_inc = (cycles == 16'hFFFF) ? cycles
                                           : cycles + 16'd1;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      pc      <= START_ADDR;
      inst_pc <= '0;
      inst    <= '0;
      valid   <= 1'b0;
      cycles  <= '0;
    end else begin
      state   <= state_nx;
      pc      <= pc_nx;
      inst_pc <= inst_pc_nx;
      inst    <= inst_nx;
      valid   <= valid_nx;
      cycles  <= cycles_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    inst_pc_nx = inst_pc;
    inst_nx    = inst;
    valid_nx   = valid;
    cycles_nx  = cycles;

    unique case (state)
      IDLE, DONE: begin
        if (bus.Start) begin
          state_nx  = RUN;
          pc_nx     = START_ADDR;
          cycles_nx = '0;
          valid_nx  = 1'b0;
        end
      end
      RUN: begin
        cycles_nx = cycles_inc;
        if (!bus.Stall) begin
          unique case (1'b1)
            halt_go: begin
              state_nx = DONE;
              valid_nx = 1'b0;
            end
            abs_go: begin
              pc_nx    = bus.Target;
              valid_nx = 1'b0;
            end
            rel_go: begin
              pc_nx    = inst_pc + bus.Target;
              valid_nx = 1'b0;
            end
            default: begin
              inst_nx    = bus.InstIn;
              inst_pc_nx = pc;
              valid_nx   = 1'b1;
              pc_nx      = pc + 1'b1;
            end
          endcase
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.InstAddress = pc;
  assign bus.InstOut     = inst;
  assign bus.InstPC      = inst_pc;
  assign bus.InstValid   = valid;
  assign bus.Busy        = (state == RUN);
  assign bus.Done        = (state == DONE);
  assign bus.CycleCount  = cycles;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: reset, straight-line fetch, branches,
// PC wrap, stall with pending events, halt, restart and mid-run reset.
module tb_fetch_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  fetch_sequencer_if #(.A(16), .W(9)) bus ();

  fetch_sequencer #(.A(16), .W(9), .START_ADDR(16'h0000)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus.master)
  );

  function automatic logic [8:0] rom_word(input logic [15:0] a);
    case (a)
      16'h0000: rom_word = 9'h011;
      16'h0001: rom_word = 9'h022;
      16'h0002: rom_word = 9'h033;
      16'h0003: rom_word = 9'h044;
      default:  rom_word = a[8:0] ^ 9'h155;
    endcase
  endfunction

  assign bus.InstIn = rom_word(bus.InstAddress);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"},  32'(bus.Busy),        32'h0);
    chk({tag, "_done"},  32'(bus.Done),        32'h0);
    chk({tag, "_addr"},  32'(bus.InstAddress), 32'h0);
    chk({tag, "_valid"}, 32'(bus.InstValid),   32'h0);
    chk({tag, "_out"},   32'(bus.InstOut),     32'h0);
    chk({tag, "_ipc"},   32'(bus.InstPC),      32'h0);
    chk({tag, "_cc"},    32'(bus.CycleCount),  32'h0);
  endtask

  logic [8:0] line_exp [4];

  initial begin
    checks    = 0;
    failures  = 0;
    line_exp  = '{9'h011, 9'h022, 9'h033, 9'h044};
    rst_n     = 1'b1;
    bus.Start     = 1'b0;
    bus.Stall     = 1'b0;
    bus.BranchAbs = 1'b0;
    bus.BranchRel = 1'b0;
    bus.HaltReq   = 1'b0;
    bus.Target    = '0;

    #2 rst_n = 1'b0;
    #1 chk_reset("por");
    #5 rst_n = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_addr",  32'(bus.InstAddress), 32'h0);
      chk("idle_valid", 32'(bus.InstValid),   32'h0);
      chk("idle_busy",  32'(bus.Busy),        32'h0);
    end

    // Run 1: straight-line fetch then halt
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    chk("r1_busy",  32'(bus.Busy),        32'h1);
    chk("r1_done",  32'(bus.Done),        32'h0);
    chk("r1_addr",  32'(bus.InstAddress), 32'h0);
    chk("r1_valid", 32'(bus.InstValid),   32'h0);
    chk("r1_cc0",   32'(bus.CycleCount),  32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("line_out",   32'(bus.InstOut),    32'(line_exp[i]));
      chk("line_ipc",   32'(bus.InstPC),     32'(i));
      chk("line_valid", 32'(bus.InstValid),  32'h1);
      chk("line_cc",    32'(bus.CycleCount), 32'(i + 1));
    end
    bus.HaltReq = 1'b1;
    step();
    bus.HaltReq = 1'b0;
    chk("h1_done",  32'(bus.Done),        32'h1);
    chk("h1_busy",  32'(bus.Busy),        32'h0);
    chk("h1_valid", 32'(bus.InstValid),   32'h0);
    chk("h1_addr",  32'(bus.InstAddress), 32'h4);
    chk("h1_cc",    32'(bus.CycleCount),  32'h5);
    step();
    step();
    chk("h1_hold_done", 32'(bus.Done),        32'h1);
    chk("h1_hold_cc",   32'(bus.CycleCount),  32'h5);
    chk("h1_hold_addr", 32'(bus.InstAddress), 32'h4);

    // Run 2: absolute branch, relative branch with wrap, stall
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    chk("r2_done", 32'(bus.Done),       32'h0);
    chk("r2_busy", 32'(bus.Busy),       32'h1);
    chk("r2_cc0",  32'(bus.CycleCount), 32'h0);
    step();
    step();
    step();
    chk("r2_ipc2", 32'(bus.InstPC),  32'h2);
    chk("r2_out2", 32'(bus.InstOut), 32'h033);
    bus.BranchAbs = 1'b1;
    bus.Target    = 16'h0040;
    step();
    bus.BranchAbs = 1'b0;
    chk("abs_bubble", 32'(bus.InstValid),   32'h0);
    chk("abs_addr",   32'(bus.InstAddress), 32'h0040);
    step();
    chk("abs_ipc",   32'(bus.InstPC),    32'h0040);
    chk("abs_out",   32'(bus.InstOut),   32'h115);
    chk("abs_valid", 32'(bus.InstValid), 32'h1);
    bus.BranchAbs = 1'b1;
    bus.Target    = 16'h0001;
    step();
    bus.BranchAbs = 1'b0;
    step();
    chk("abs1_ipc", 32'(bus.InstPC),  32'h1);
    chk("abs1_out", 32'(bus.InstOut), 32'h022);
    bus.BranchRel = 1'b1;
    bus.Target    = 16'hFFFD;
    step();
    bus.BranchRel = 1'b0;
    chk("rel_bubble", 32'(bus.InstValid),   32'h0);
    chk("rel_addr",   32'(bus.InstAddress), 32'hFFFE);
    step();
    chk("wrap_ipc0", 32'(bus.InstPC),    32'hFFFE);
    chk("wrap_out0", 32'(bus.InstOut),   32'h0AB);
    chk("wrap_v0",   32'(bus.InstValid), 32'h1);
    step();
    chk("wrap_ipc1", 32'(bus.InstPC),  32'hFFFF);
    chk("wrap_out1", 32'(bus.InstOut), 32'h0AA);
    step();
    chk("wrap_ipc2", 32'(bus.InstPC),      32'h0000);
    chk("wrap_out2", 32'(bus.InstOut),     32'h011);
    chk("wrap_addr", 32'(bus.InstAddress), 32'h0001);
    chk("r2_cc11",   32'(bus.CycleCount),  32'd11);

    bus.Stall     = 1'b1;
    bus.BranchAbs = 1'b1;
    bus.Target    = 16'h0040;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_ipc",   32'(bus.InstPC),      32'h0);
      chk("stall_out",   32'(bus.InstOut),     32'h011);
      chk("stall_valid", 32'(bus.InstValid),   32'h1);
      chk("stall_addr",  32'(bus.InstAddress), 32'h1);
    end
    chk("stall_cc", 32'(bus.CycleCount), 32'd14);
    bus.Stall   = 1'b0;
    bus.HaltReq = 1'b1;
    step();
    bus.HaltReq   = 1'b0;
    bus.BranchAbs = 1'b0;
    chk("sh_done",  32'(bus.Done),        32'h1);
    chk("sh_busy",  32'(bus.Busy),        32'h0);
    chk("sh_valid", 32'(bus.InstValid),   32'h0);
    chk("sh_addr",  32'(bus.InstAddress), 32'h1);
    chk("sh_cc",    32'(bus.CycleCount),  32'd15);

    // Run 3: ignored events, halt at InstPC 5, restart, mid-run reset
    bus.Start = 1'b1;
    step();
    bus.Start     = 1'b0;
    bus.BranchAbs = 1'b1;
    bus.Target    = 16'h0040;
    step();
    bus.BranchAbs = 1'b0;
    chk("nv_ipc",   32'(bus.InstPC),      32'h0);
    chk("nv_out",   32'(bus.InstOut),     32'h011);
    chk("nv_valid", 32'(bus.InstValid),   32'h1);
    chk("nv_addr",  32'(bus.InstAddress), 32'h1);
    step();
    step();
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    chk("sir_ipc",  32'(bus.InstPC),      32'h3);
    chk("sir_addr", 32'(bus.InstAddress), 32'h4);
    chk("sir_cc",   32'(bus.CycleCount),  32'd4);
    step();
    step();
    chk("r3_ipc5", 32'(bus.InstPC), 32'h5);
    bus.HaltReq = 1'b1;
    step();
    bus.HaltReq = 1'b0;
    chk("h3_done", 32'(bus.Done),       32'h1);
    chk("h3_busy", 32'(bus.Busy),       32'h0);
    chk("h3_cc",   32'(bus.CycleCount), 32'd7);
    step();
    step();
    chk("h3_hold_cc",   32'(bus.CycleCount), 32'd7);
    chk("h3_hold_done", 32'(bus.Done),       32'h1);
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    chk("rs_done", 32'(bus.Done),        32'h0);
    chk("rs_busy", 32'(bus.Busy),        32'h1);
    chk("rs_cc",   32'(bus.CycleCount),  32'h0);
    chk("rs_addr", 32'(bus.InstAddress), 32'h0);
    step();
    chk("rs_out", 32'(bus.InstOut), 32'h011);
    chk("rs_ipc", 32'(bus.InstPC),  32'h0);
    step();
    #3 rst_n = 1'b0;
    #1 chk_reset("midrst");
    #2 rst_n = 1'b1;
    step();
    chk("post_busy",  32'(bus.Busy),        32'h0);
    chk("post_addr",  32'(bus.InstAddress), 32'h0);
    chk("post_valid", 32'(bus.InstValid),   32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
